// File: rtl/ahb_lite_single_master_if.sv
// ahb_lite_single_master_if: command/response handshake plus AHB-Lite bus signals
interface ahb_lite_single_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_err;
  logic          hsel;
  logic          hwrite;
  logic          hready;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          hready_resp;
  logic [1:0]    hresp;
  logic [DW-1:0] hrdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output hsel, hwrite, hready, htrans, hsize, hburst, haddr, hwdata,
    input  hready_resp, hresp, hrdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  hsel, hwrite, hready, htrans, hsize, hburst, haddr, hwdata,
    output hready_resp, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_single_master.sv
// ahb_lite_single_master: valid/ready command to single NONSEQ AHB-Lite transfer with timeout
module ahb_lite_single_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic hclk,
  input logic hreset,
  ahb_lite_single_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tmo;
  logic          illegal;
  logic          hsel_q;
  logic          hwrite_q;
  logic [1:0]    htrans_q;
  logic [2:0]    hsize_q;
  logic [AW-1:0] haddr_q;
  logic [DW-1:0] hwdata_q;
  logic [DW-1:0] wdata_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;
  logic [1:0]    rsp_err_q;
  assign cnt_d   = cnt_q + 1'b1;
  assign tmo     = (TIMEOUT != 0) && (cnt_d == CW'(TIMEOUT));
  assign illegal = (bus.cmd_size > 3'd2) || (bus.cmd_size == 3'd1 && bus.cmd_addr[0]) ||
                   (bus.cmd_size == 3'd2 && bus.cmd_addr[1:0] != 2'b00);
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.hready    = bus.hready_resp;
  assign bus.hburst    = 3'b000;
  assign bus.hsel      = hsel_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.htrans    = htrans_q;
  assign bus.hsize     = hsize_q;
  assign bus.haddr     = haddr_q;
  assign bus.hwdata    = hwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  // transfer FSM: command capture, address/data phases, local error and timeout responses
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hsel_q      <= 1'b0;
      hwrite_q    <= 1'b0;
      htrans_q    <= 2'b00;
      hsize_q     <= 3'd0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          wdata_q <= bus.cmd_wdata;
          if (illegal) state_q <= RESP;
          else begin
            state_q  <= ADDR;
            htrans_q <= 2'b10;
            hsel_q   <= 1'b1;
            haddr_q  <= bus.cmd_addr;
            hwrite_q <= bus.cmd_write;
            hsize_q  <= bus.cmd_size;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 2'b11;
          rsp_rdata_q <= '0;
        end
        ADDR: if (bus.hready_resp) begin
          state_q  <= DATA;
          htrans_q <= 2'b00;
          hsel_q   <= 1'b0;
          hwdata_q <= hwrite_q ? wdata_q : '0;
          cnt_q    <= '0;
        end else if (tmo) begin
          state_q     <= IDLE;
          htrans_q    <= 2'b00;
          hsel_q      <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 2'b10;
          rsp_rdata_q <= '0;
          cnt_q       <= '0;
        end else cnt_q <= cnt_d;
        DATA: if (bus.hready_resp) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= (bus.hresp == 2'b01) ? 2'b01 : 2'b00;
          rsp_rdata_q <= (!hwrite_q && bus.hresp != 2'b01) ? bus.hrdata : '0;
          cnt_q       <= '0;
        end else if (tmo) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 2'b10;
          rsp_rdata_q <= '0;
          cnt_q       <= '0;
        end else cnt_q <= cnt_d;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_lite_single_master.sv
// tb_ahb_lite_single_master: directed checks of transfers, wait states, errors, illegal commands, timeout, reset
module tb_ahb_lite_single_master;
  logic hclk = 1'b0;
  logic hreset;
  int   tests = 0;
  int   fails = 0;
  ahb_lite_single_master_if #(.AW(32), .DW(32)) bus ();
  ahb_lite_single_master #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus.master)
  );
  always #5 hclk = ~hclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge hclk);
    #1;
  endtask
  task automatic cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_size  = size;
    bus.cmd_wdata = wd;
    step();
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    hreset          = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_size    = '0;
    bus.cmd_wdata   = '0;
    bus.hready_resp = 1'b1;
    bus.hresp       = 2'b00;
    bus.hrdata      = '0;
    repeat (10) step();
    hreset = 1'b0;
    step();
    chk("rst_htrans", bus.htrans, 0);
    chk("rst_hsel", bus.hsel, 0);
    chk("rst_haddr", bus.haddr, 0);
    chk("rst_hwdata", bus.hwdata, 0);
    chk("rst_hwrite", bus.hwrite, 0);
    chk("rst_hsize", bus.hsize, 0);
    chk("rst_hburst", bus.hburst, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    // zero-wait write
    cmd(1'b1, 32'h04, 3'd2, 32'h1);
    chk("wr_addr_htrans", bus.htrans, 2);
    chk("wr_addr_hsel", bus.hsel, 1);
    chk("wr_addr_haddr", bus.haddr, 32'h04);
    chk("wr_addr_hwrite", bus.hwrite, 1);
    chk("wr_addr_hsize", bus.hsize, 2);
    chk("wr_addr_cmd_ready", bus.cmd_ready, 0);
    step();
    chk("wr_data_htrans", bus.htrans, 0);
    chk("wr_data_hsel", bus.hsel, 0);
    chk("wr_data_hwdata", bus.hwdata, 32'h1);
    chk("wr_data_rsp_valid", bus.rsp_valid, 0);
    step();
    chk("wr_rsp_valid", bus.rsp_valid, 1);
    chk("wr_rsp_err", bus.rsp_err, 0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 0);
    chk("wr_rsp_cmd_ready", bus.cmd_ready, 1);
    step();
    chk("wr_rsp_pulse", bus.rsp_valid, 0);
    // read with two data-phase wait states
    cmd(1'b0, 32'h04, 3'd2, 32'hFFFF_FFFF);
    chk("rd_addr_hwrite", bus.hwrite, 0);
    step();
    chk("rd_data_hwdata", bus.hwdata, 0);
    bus.hready_resp = 1'b0;
    bus.hrdata      = 32'hDEAD_BEEF;
    step();
    chk("rd_wait1_rsp", bus.rsp_valid, 0);
    chk("rd_wait1_hready", bus.hready, 0);
    step();
    chk("rd_wait2_rsp", bus.rsp_valid, 0);
    bus.hready_resp = 1'b1;
    bus.hrdata      = 32'h1;
    step();
    chk("rd_rsp_valid", bus.rsp_valid, 1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'h1);
    chk("rd_rsp_err", bus.rsp_err, 0);
    bus.hrdata = 32'hDEAD_BEEF;
    step();
    chk("rd_rsp_pulse", bus.rsp_valid, 0);
    // two-cycle slave ERROR on write
    cmd(1'b1, 32'h08, 3'd2, 32'hAB);
    step();
    bus.hready_resp = 1'b0;
    bus.hresp       = 2'b01;
    step();
    chk("err1_htrans", bus.htrans, 0);
    chk("err1_rsp_valid", bus.rsp_valid, 0);
    bus.hready_resp = 1'b1;
    step();
    chk("err2_htrans", bus.htrans, 0);
    chk("err_rsp_valid", bus.rsp_valid, 1);
    chk("err_rsp_err", bus.rsp_err, 1);
    chk("err_rsp_rdata", bus.rsp_rdata, 0);
    bus.hresp = 2'b00;
    step();
    // misaligned word, then illegal size
    cmd(1'b0, 32'h06, 3'd2, 32'h0);
    chk("mis_hsel0", bus.hsel, 0);
    chk("mis_rsp0", bus.rsp_valid, 0);
    step();
    chk("mis_hsel1", bus.hsel, 0);
    chk("mis_rsp_valid", bus.rsp_valid, 1);
    chk("mis_rsp_err", bus.rsp_err, 3);
    cmd(1'b1, 32'h00, 3'd3, 32'h5);
    chk("sz_hsel0", bus.hsel, 0);
    chk("sz_rsp_pulse", bus.rsp_valid, 0);
    step();
    chk("sz_hsel1", bus.hsel, 0);
    chk("sz_rsp_valid", bus.rsp_valid, 1);
    chk("sz_rsp_err", bus.rsp_err, 3);
    step();
    // address-phase timeout with hready_resp stuck low
    bus.hready_resp = 1'b0;
    cmd(1'b0, 32'h10, 3'd2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo_htrans%0d", i), bus.htrans, 2);
      chk($sformatf("tmo_rsp%0d", i), bus.rsp_valid, 0);
      step();
    end
    chk("tmo_htrans_end", bus.htrans, 0);
    chk("tmo_hsel_end", bus.hsel, 0);
    chk("tmo_rsp_valid", bus.rsp_valid, 1);
    chk("tmo_rsp_err", bus.rsp_err, 2);
    step();
    // reset mid address phase
    cmd(1'b1, 32'h20, 3'd2, 32'h7);
    chk("rstmid_htrans", bus.htrans, 2);
    step();
    hreset = 1'b1;
    step();
    hreset          = 1'b0;
    bus.hready_resp = 1'b1;
    chk("rstmid_htrans0", bus.htrans, 0);
    chk("rstmid_hsel0", bus.hsel, 0);
    chk("rstmid_cmd_ready", bus.cmd_ready, 1);
    chk("rstmid_rsp0", bus.rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rstmid_rsp_after%0d", i), bus.rsp_valid, 0);
      chk($sformatf("rstmid_htrans_after%0d", i), bus.htrans, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ahb_lite_single_master.md
Name: ahb_lite_single_master

Overview:
- AHB-Lite initiator for the calculator slave subsystem: turns a valid/ready command interface into single NONSEQ transfers (HBURST=SINGLE) and returns one response per command.
- Sits between a local controller (CPU stub, test sequencer) and AHB slaves such as ahb_clac_top; drives the bus signals the slave samples and consumes hready_resp/hresp/hrdata.
- No pipelining: one outstanding transfer; a local timeout guards against a hung slave.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed 32 in this release)
- TIMEOUT, 16, max consecutive hready_resp=0 cycles per phase before abort; 0 disables

Ports:
- hclk  in  1  bus clock, all logic on rising edge
- hreset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AW  byte address
- cmd_size  in  3  HSIZE encoding (0=byte, 1=half, 2=word)
- cmd_wdata  in  DW  write data, placed on hwdata unchanged (caller aligns lanes)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DW  read data (0 for writes/errors)
- rsp_err  out  2  00 OKAY, 01 slave ERROR, 10 timeout, 11 illegal size/misaligned
- hsel, hwrite, hready  out  1  slave select, direction, bus-ready to slave (hready = hready_resp)
- htrans  out  2  IDLE=00, NONSEQ=10 only
- hsize, hburst  out  3  transfer size; hburst constant 000
- haddr  out  AW;  hwdata  out  DW
- hready_resp  in  1;  hresp  in  2  (00 OKAY, 01 ERROR);  hrdata  in  DW

Behaviour:
- Reset (hreset=1 at posedge): state IDLE, htrans=IDLE, hsel=0, hwrite=0, haddr=0, hwdata=0, hsize=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0. An in-flight transfer is dropped; no response issued.
- All bus and rsp outputs are registered except hready (combinational copy of hready_resp) and cmd_ready (=1 only in IDLE).
- FSM IDLE -> ADDR -> DATA -> IDLE; plus RESP for local errors.
- IDLE: on cmd_valid at posedge, command captured. Legal -> ADDR, driving htrans=NONSEQ, hsel=1, haddr, hwrite, hsize from the next cycle. Illegal -> RESP.
- Illegal: size>2, size=1 with addr[0]=1, size=2 with addr[1:0]!=0. No bus activity; rsp_valid=1, rsp_err=11 in the cycle after capture; back to IDLE.
- ADDR: held stable while hready_resp=0. At posedge with hready_resp=1 -> DATA; from the next cycle htrans=IDLE, hsel=0, hwdata=captured wdata (writes; 0 for reads). haddr/hwrite/hsize hold their last values.
- DATA, at posedge with hready_resp=1:
  - hresp=OKAY: rsp_valid=1 next cycle; rsp_rdata=hrdata sampled at that edge for reads, 0 for writes; rsp_err=00.
  - hresp=ERROR: rsp_err=01, rsp_rdata=0.
  - Either way -> IDLE. hwdata holds until the next command.
- ERROR first cycle (hready_resp=0, hresp=01): no action needed, htrans is already IDLE; the response is taken on the second cycle.
- Timeout: counter increments each ADDR/DATA cycle with hready_resp=0 and clears on phase change. When it reaches TIMEOUT (TIMEOUT>0): next cycle htrans=IDLE, hsel=0, rsp_valid=1, rsp_err=10 -> IDLE.
- Latency: accept edge T0, address phase T0–T1, data phase T1–T2 (zero wait), rsp_valid during T2–T3, next accept at T3 earliest.
- Each wait state adds one cycle. rsp_valid is never high two consecutive cycles.
- cmd_valid while cmd_ready=0 is ignored; the caller must hold it.

Test Plan:
- Reset held 10 cycles, then released -> all outputs 0, cmd_ready=1, htrans=00.
- Write addr 0x04, size 2, wdata 0x00000001, zero-wait slave -> htrans=10/haddr=0x04/hwrite=1 for 1 cycle, then hwdata=0x1; rsp_valid at T2–T3, rsp_err=00.
- Read 0x04 with slave returning 0x00000001 after 2 wait states in data phase -> rsp_valid 2 cycles later than zero-wait, rsp_rdata=0x00000001.
- Slave 2-cycle ERROR on write to 0x08 -> rsp_err=01, rsp_rdata=0, htrans stays 00 during both ERROR cycles.
- Commands size=2 addr 0x06, then size=3 addr 0 -> rsp_err=11 each, hsel never asserted.
- TIMEOUT=4, hready_resp tied 0 -> htrans=10 for 4 cycles, then hsel=0 and rsp_err=10; hreset pulsed mid-ADDR -> no rsp_valid, state IDLE.
